// File: rtl/binary_decoder_scan.sv
// ============================================================================
// Module   : binary_decoder_scan
// Brief    : Registered N-to-2^N one-hot decoder with an autonomous scan mode
//            for LED digit/row multiplexing. Define BCODE_ACTIVE_LOW_EN for
//            one-cold (active-low) bcode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module binary_decoder_scan #(
    parameter int N        = 4,
    parameter int SCAN_DIV = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 mode,
    input  logic                 load,
    input  logic [N-1:0]         a,
    output logic [(1<<N)-1:0]    bcode,
    output logic [N-1:0]         idx,
    output logic                 wrap
);

    localparam int W  = 1 << N;
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    localparam logic [PW-1:0] c_TC  = PW'(SCAN_DIV - 1);
    localparam logic [W-1:0]  c_ONE = W'(1);

`ifdef BCODE_ACTIVE_LOW_EN
    localparam logic [W-1:0]  c_POL = {W{1'b1}};
`else
    localparam logic [W-1:0]  c_POL = {W{1'b0}};
`endif

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIRECT = 2'd1,
        S_SCAN   = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [N-1:0]    r_idx;
    logic [N-1:0]    w_idx_nxt;
    logic [PW-1:0]   r_presc;
    logic [PW-1:0]   w_presc_nxt;
    logic [W-1:0]    r_bcode;
    logic [W-1:0]    w_bcode_nxt;
    logic            r_wrap;
    logic            w_wrap_nxt;

    // Actions at each edge follow the state being entered, so a direct
    // decode lands on bcode one edge after a is sampled.
    always_comb begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = r_idx;
        w_presc_nxt = '0;
        w_wrap_nxt  = 1'b0;
        w_bcode_nxt = c_POL;

        if (en) begin
            w_state_nxt = mode ? S_SCAN : S_DIRECT;
        end

        case (w_state_nxt)
            S_DIRECT: begin
                w_idx_nxt = a;
            end
            S_SCAN: begin
                if (load) begin
                    w_idx_nxt = a;
                end else if (r_state != S_SCAN) begin
                    w_presc_nxt = '0;
                end else if (r_presc == c_TC) begin
                    w_idx_nxt  = r_idx + N'(1);
                    w_wrap_nxt = &r_idx;
                end else begin
                    w_presc_nxt = r_presc + PW'(1);
                end
            end
            default: begin
            end
        endcase

        if (w_state_nxt != S_IDLE) begin
            w_bcode_nxt = (c_ONE << w_idx_nxt) ^ c_POL;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_presc <= '0;
            r_bcode <= c_POL;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_presc <= w_presc_nxt;
            r_bcode <= w_bcode_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    assign bcode = r_bcode;
    assign idx   = r_idx;
    assign wrap  = r_wrap;

endmodule

`default_nettype wire

// File: tb/tb_binary_decoder_scan.sv
// ============================================================================
// Module   : tb_binary_decoder_scan
// Brief    : Self-checking bench for binary_decoder_scan (N=4, SCAN_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_binary_decoder_scan;

    localparam int N        = 4;
    localparam int SCAN_DIV = 4;
    localparam int W        = 1 << N;

`ifdef BCODE_ACTIVE_LOW_EN
    localparam logic [15:0] c_POL = 16'hFFFF;
`else
    localparam logic [15:0] c_POL = 16'h0000;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          en;
    logic          mode;
    logic          load;
    logic [N-1:0]  a;
    logic [W-1:0]  bcode;
    logic [N-1:0]  idx;
    logic          wrap;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: where the index is, how many cycles have elapsed since
    // the scan last (re)started or stepped, and whether the decoder is live.
    int m_idx;
    int m_phase;
    bit m_scan;
    bit m_on;
    bit m_wrap;

    binary_decoder_scan #(.N(N), .SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .load  (load),
        .a     (a),
        .bcode (bcode),
        .idx   (idx),
        .wrap  (wrap)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_bcode();
        if (!m_on) return c_POL;
        return (16'(1) << m_idx) ^ c_POL;
    endfunction

    task automatic model_reset();
        m_idx   = 0;
        m_phase = 0;
        m_scan  = 0;
        m_on    = 0;
        m_wrap  = 0;
    endtask

    task automatic model_edge(input bit e, input bit m, input bit l, input int av);
        m_wrap = 0;
        if (!e) begin
            m_on   = 0;
            m_scan = 0;
        end else if (!m) begin
            m_on   = 1;
            m_scan = 0;
            m_idx  = av;
        end else begin
            m_on = 1;
            if (!m_scan || l) begin
                if (l) m_idx = av;
                m_phase = 0;
            end else begin
                m_phase++;
                if (m_phase == SCAN_DIV) begin
                    m_phase = 0;
                    m_idx   = (m_idx + 1) % W;
                    m_wrap  = (m_idx == 0);
                end
            end
            m_scan = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".bcode"}, 64'(bcode), 64'(exp_bcode()));
        chk({tag, ".idx"},   64'(idx),   64'(m_idx));
        chk({tag, ".wrap"},  64'(wrap),  64'(m_wrap));
    endtask

    // One clock: drive inputs, take the edge, update the model, check outputs.
    task automatic cyc(input bit e, input bit m, input bit l, input int av, input string tag);
        en   = e;
        mode = m;
        load = l;
        a    = N'(av);
        @(posedge clk);
        model_edge(e, m, l, av);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; a = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.bcode_const", 64'(bcode), 64'(16'h0000 ^ c_POL));
        reset = 1'b0;
        cyc(0, 0, 0, 0, "idle_after_reset");

        // Direct sweep a = 0..15
        for (int i = 0; i < W; i++) begin
            cyc(1, 0, 0, i, "direct_sweep");
            chk("direct_sweep.const", 64'(bcode), 64'((16'(1) << i) ^ c_POL));
            $display("[TB] a=%h bcode=%h", a, bcode);
        end

        // Scan rate and wrap starting from idx=14
        cyc(1, 0, 0, 14, "pre_scan14");
        for (int i = 0; i < 10; i++) begin
            cyc(1, 1, 0, 0, "scan_wrap");
            if (m_wrap) chk("scan_wrap.bcode_const", 64'(bcode), 64'(16'h0001 ^ c_POL));
        end

        // Load collides with terminal count
        for (int i = 0; i < 2 * SCAN_DIV && m_phase != SCAN_DIV - 1; i++)
            cyc(1, 1, 0, 0, "scan_to_tc");
        chk("tc_reached", 64'(m_phase), 64'(SCAN_DIV - 1));
        cyc(1, 1, 1, 9, "load_tc");
        chk("load_tc.bcode_const", 64'(bcode), 64'(16'h0200 ^ c_POL));
        chk("load_tc.wrap_const",  64'(wrap),  64'(0));
        for (int i = 0; i < SCAN_DIV; i++) cyc(1, 1, 0, 0, "after_load");
        chk("after_load.idx_const", 64'(idx), 64'(10));

        // DIRECT idx=3 -> SCAN -> held 4 cycles then steps; then drop en
        cyc(1, 0, 0, 3, "direct3");
        for (int i = 0; i < SCAN_DIV; i++) begin
            cyc(1, 1, 0, 7, "scan_from3");
            chk("scan_from3.hold", 64'(bcode), 64'(16'h0008 ^ c_POL));
        end
        cyc(1, 1, 0, 7, "scan_step4");
        chk("scan_step4.const", 64'(bcode), 64'(16'h0010 ^ c_POL));
        cyc(0, 1, 0, 7, "drop_en");
        chk("drop_en.idx_hold", 64'(idx), 64'(4));

        // Active-low DIRECT a=2 (active-high gives 0x0004)
        cyc(1, 0, 0, 2, "direct2");
        chk("direct2.const", 64'(bcode), 64'(16'h0004 ^ c_POL));

        // Asynchronous reset mid-scan with idx=5
        cyc(1, 0, 0, 5, "direct5");
        cyc(1, 1, 0, 0, "scan5");
        cyc(1, 1, 0, 0, "scan5b");
        #2 reset = 1'b1;
        model_reset();
        #1;
        check_all("async_reset");
        #1 reset = 1'b0;
        cyc(0, 0, 0, 0, "release_idle");

        // Randomised traffic, with occasional asynchronous reset pulses
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(63) == 0) begin
                #2 reset = 1'b1;
                model_reset();
                #1;
                check_all("rand_reset");
                #1 reset = 1'b0;
            end
            cyc($urandom_range(7) != 0, $urandom_range(3) != 0,
                $urandom_range(15) == 0, int'($urandom_range(W - 1)), "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
